keccak_host: RTL and testbench
==============================

KECCAK_HOST -- requirements
Module: keccak_host

Interface
REQ-001 SHALL have parameters: BW_DATA, default 64, keccak word width in bits; BW_IBLEN, default 16, input byte-length width; BW_OBLEN, default 16, output byte-length width.
REQ-002 SHALL have ports (clock and reset first), each given as name, direction, width, meaning:
- i_clk, in, 1, clock.
- i_rstn, in, 1, reset; asynchronous, active-low.
- i_cmd_valid, in, 1, command offered.
- o_cmd_ready, out, 1, command accepted when both are high.
- i_cmd_mode, in, 2, mode: 0 SHAKE128, 1 SHAKE256, 2 SHA3_256, 3 SHA3_512.
- i_cmd_ilen, in, BW_IBLEN, message length in bytes.
- i_cmd_olen, in, BW_OBLEN, requested output bytes; used only for SHAKE modes.
- i_msg_byte, in, 8, message byte.
- i_msg_valid, in, 1, message byte offered.
- o_msg_ready, out, 1, message byte accepted when both are high.
- o_kc_mode, out, 2, mode driven to the sponge.
- o_kc_ibytes, out, BW_DATA, packed input word.
- o_kc_ibytes_valid, out, 1, input word valid.
- i_kc_ibytes_ready, in, 1, sponge is taking input words.
- o_kc_ibytes_len, out, BW_IBLEN, message length in bytes.
- o_kc_obytes_len, out, BW_OBLEN, output length in bytes.
- i_kc_obytes, in, BW_DATA, output word from the sponge.
- i_kc_obytes_valid, in, 1, output word valid; single-cycle per word.
- i_kc_obytes_done, in, 1, sponge done pulse.
- o_dout, out, BW_DATA, output word.
- o_dout_valid, out, 1, output word valid.
- o_dout_nbytes, out, 4, number of valid bytes in o_dout (1..8).
- o_dout_last, out, 1, marks the final output word.
- o_done, out, 1, transaction-complete pulse.
- o_err, out, 1, error pulse.
- o_busy, out, 1, transaction in progress.

Function
REQ-003 FSM states SHALL be IDLE, SEND, COLLECT, DONE.
REQ-004 IDLE: o_cmd_ready=1; on cmd handshake SHALL latch mode, ilen and olen, and go to SEND.
REQ-005 Cmd with ilen==0, or with olen==0 in a SHAKE mode, SHALL be consumed, SHALL produce a 1-cycle o_err, and the FSM SHALL stay in IDLE.
REQ-006 Latched olen_eff SHALL be olen for SHAKE, 32 for SHA3_256, and 64 for SHA3_512.
REQ-007 o_kc_mode, o_kc_ibytes_len and o_kc_obytes_len SHALL drive the latched mode, ilen and olen_eff, held constant from SEND entry until IDLE.
REQ-008 Packing: message byte k SHALL occupy o_kc_ibytes[63-8*(k%8) -: 8], i.e. the first byte is in the MSBs.
REQ-009 A word SHALL be complete after 8 bytes, or after the final byte (k==ilen-1); byte lanes not filled in the final word SHALL be zero.
REQ-010 o_msg_ready SHALL be 1 only in SEND with no word pending and bytes remaining >0.
REQ-011 Throughput SHALL be 1 byte/cycle into the packer.
REQ-012 A completed word SHALL set o_kc_ibytes_valid=1 on the next cycle and hold o_kc_ibytes stable until the cycle where i_kc_ibytes_ready=1; the word is then transferred and valid clears.
REQ-013 Words sent SHALL equal ceil(ilen/8); after the last transfer the FSM SHALL go to COLLECT.
REQ-014 COLLECT: each i_kc_obytes_valid SHALL register i_kc_obytes to o_dout with o_dout_valid=1 for 1 cycle (latency 1).
- Words with index < ceil(olen_eff/8)-1: o_dout_nbytes=8.
- Final word: o_dout_nbytes = olen_eff%8 (8 if 0), o_dout_last=1, and the unused low byte lanes zeroed.
REQ-015 Output words beyond ceil(olen_eff/8) SHALL be dropped with no o_dout_valid.
REQ-016 No backpressure on o_dout: the consumer SHALL accept every valid word.
REQ-017 i_kc_obytes_done in COLLECT SHALL move the FSM to DONE. If fewer than ceil(olen_eff/8) words were received, o_err SHALL pulse in the DONE cycle.
REQ-018 DONE SHALL pulse o_done=1 for 1 cycle, then go to IDLE.
REQ-019 o_busy SHALL be 1 in SEND, COLLECT and DONE.
REQ-020 i_kc_obytes_valid in IDLE or SEND SHALL be ignored; i_msg_valid outside SEND SHALL be ignored.
REQ-021 Internal byte counter SHALL be BW_IBLEN bits wide and output-word counter BW_OBLEN-3 bits wide, with no wrap within a legal transaction.

Reset
REQ-022 On i_rstn=0, including mid-transaction, the FSM SHALL return to IDLE, all counters and latches SHALL clear, and all outputs SHALL go to 0, except o_cmd_ready=1 after reset release.
REQ-023 A partially packed word SHALL be discarded on reset.

Verification
REQ-024 SHA3_256, ilen=3 bytes 0x61,0x62,0x63 -> one kc word 0x6162630000000000 transferred; 4 dout words, nbytes 8, last on 4th; o_done pulse.
REQ-025 SHAKE128, ilen=16, olen=34 -> 2 kc words; 5 dout words, last nbytes=2 with low 6 bytes zero; 6th sponge word dropped.
REQ-026 i_kc_ibytes_ready held 0 for 5 cycles with a word pending -> o_kc_ibytes stable, o_msg_ready=0, no byte lost.
REQ-027 Cmd ilen=0, and separately SHAKE256 with olen=0 -> o_err 1 cycle each, o_busy stays 0.
REQ-028 i_kc_obytes_done after 2 of 8 words in SHA3_512 -> o_err and o_done in the same cycle, no o_dout_last.
REQ-029 Reset asserted in SEND after 5 of 20 bytes -> all outputs 0 and IDLE; a new cmd then completes correctly.

Source files
------------

// File: rtl/keccak_host_if.sv
// Bus bundle between a Keccak host front-end and its surroundings: command,
// message byte stream, sponge word interface and trimmed output words.
interface keccak_host_if #(
  parameter int BW_DATA  = 64,
  parameter int BW_IBLEN = 16,
  parameter int BW_OBLEN = 16
);
  logic                i_cmd_valid;
  logic                o_cmd_ready;
  logic [1:0]          i_cmd_mode;
  logic [BW_IBLEN-1:0] i_cmd_ilen;
  logic [BW_OBLEN-1:0] i_cmd_olen;
  logic [7:0]          i_msg_byte;
  logic                i_msg_valid;
  logic                o_msg_ready;
  logic [1:0]          o_kc_mode;
  logic [BW_DATA-1:0]  o_kc_ibytes;
  logic                o_kc_ibytes_valid;
  logic                i_kc_ibytes_ready;
  logic [BW_IBLEN-1:0] o_kc_ibytes_len;
  logic [BW_OBLEN-1:0] o_kc_obytes_len;
  logic [BW_DATA-1:0]  i_kc_obytes;
  logic                i_kc_obytes_valid;
  logic                i_kc_obytes_done;
  logic [BW_DATA-1:0]  o_dout;
  logic                o_dout_valid;
  logic [3:0]          o_dout_nbytes;
  logic                o_dout_last;
  logic                o_done;
  logic                o_err;
  logic                o_busy;

  modport master (
    output i_cmd_valid, i_cmd_mode, i_cmd_ilen, i_cmd_olen,
    output i_msg_byte, i_msg_valid, i_kc_ibytes_ready,
    output i_kc_obytes, i_kc_obytes_valid, i_kc_obytes_done,
    input  o_cmd_ready, o_msg_ready, o_kc_mode, o_kc_ibytes, o_kc_ibytes_valid,
    input  o_kc_ibytes_len, o_kc_obytes_len, o_dout, o_dout_valid,
    input  o_dout_nbytes, o_dout_last, o_done, o_err, o_busy
  );

  modport slave (
    input  i_cmd_valid, i_cmd_mode, i_cmd_ilen, i_cmd_olen,
    input  i_msg_byte, i_msg_valid, i_kc_ibytes_ready,
    input  i_kc_obytes, i_kc_obytes_valid, i_kc_obytes_done,
    output o_cmd_ready, o_msg_ready, o_kc_mode, o_kc_ibytes, o_kc_ibytes_valid,
    output o_kc_ibytes_len, o_kc_obytes_len, o_dout, o_dout_valid,
    output o_dout_nbytes, o_dout_last, o_done, o_err, o_busy
  );
endinterface

// File: rtl/keccak_host.sv
// Keccak host front-end: packs message bytes MSB-first into sponge words and
// trims the sponge output stream to the requested length.
module keccak_host #(
  parameter int BW_DATA  = 64,
  parameter int BW_IBLEN = 16,
  parameter int BW_OBLEN = 16
) (
  input logic          i_clk,
  input logic          i_rstn,
  keccak_host_if.slave bus
);
  localparam int NB     = BW_DATA / 8;
  localparam int LANE_W = $clog2(NB);
  localparam int OW_W   = BW_OBLEN - 3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SEND    = 2'd1,
    ST_COLLECT = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  state_t              state_r, state_n;
  logic [1:0]          mode_r, mode_n;
  logic [BW_IBLEN-1:0] ilen_r, ilen_n;
  logic [BW_IBLEN-1:0] bcnt_r, bcnt_n, bcnt_inc_s;
  logic [BW_OBLEN-1:0] olen_r, olen_n;
  logic [LANE_W-1:0]   lane_r, lane_n;
  logic [BW_DATA-1:0]  pack_r, pack_n, pack_s;
  logic [BW_DATA-1:0]  kword_r, kword_n;
  logic                kvalid_r, kvalid_n;
  logic [OW_W-1:0]     ocnt_r, ocnt_n, olast_s;
  logic                ofull_r, ofull_n;
  logic [BW_DATA-1:0]  dout_r, dout_n, fin_mask_s;
  logic                dvalid_r, dvalid_n;
  logic                dlast_r, dlast_n;
  logic [3:0]          nbytes_r, nbytes_n, fin_nbytes_s;
  logic                done_r, done_n;
  logic                err_r, err_n;
  logic                busy_r, busy_n;
  logic                cmd_ready_r, cmd_ready_n;
  logic                msg_ready_r, msg_ready_n;
  logic                cmd_bad_s;

  // SHA3 modes have a fixed digest length; SHAKE uses the requested length.
  function automatic logic [BW_OBLEN-1:0] olen_eff(input logic [1:0] mode,
                                                   input logic [BW_OBLEN-1:0] olen);
    logic [BW_OBLEN-1:0] r;
    case (mode)
      2'd2:    r = BW_OBLEN'(7'd32);
      2'd3:    r = BW_OBLEN'(7'd64);
      default: r = olen;
    endcase
    return r;
  endfunction

  assign cmd_bad_s    = (bus.i_cmd_ilen == {BW_IBLEN{1'b0}}) ||
                        (!bus.i_cmd_mode[1] && (bus.i_cmd_olen == {BW_OBLEN{1'b0}}));
  assign bcnt_inc_s   = bcnt_r + BW_IBLEN'(1'b1);
  assign pack_s       = pack_r | ({bus.i_msg_byte, {(BW_DATA-8){1'b0}}} >> {lane_r, 3'b000});
  assign olast_s      = OW_W'((olen_r - BW_OBLEN'(1'b1)) >> 2'd3);
  assign fin_nbytes_s = (olen_r[2:0] == 3'd0) ? 4'd8 : {1'b0, olen_r[2:0]};
  // Keeps the top fin_nbytes_s byte lanes; a shift of the full width yields all ones.
  assign fin_mask_s   = ~({BW_DATA{1'b1}} >> {fin_nbytes_s, 3'b000});

  // Next-state, datapath and registered-output computation.
  always_comb begin
    state_n  = state_r;
    mode_n   = mode_r;
    ilen_n   = ilen_r;
    olen_n   = olen_r;
    bcnt_n   = bcnt_r;
    lane_n   = lane_r;
    pack_n   = pack_r;
    kword_n  = kword_r;
    kvalid_n = kvalid_r;
    ocnt_n   = ocnt_r;
    ofull_n  = ofull_r;
    dout_n   = {BW_DATA{1'b0}};
    dvalid_n = 1'b0;
    dlast_n  = 1'b0;
    nbytes_n = 4'd0;
    done_n   = 1'b0;
    err_n    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (bus.i_cmd_valid && cmd_ready_r && cmd_bad_s) begin
          err_n = 1'b1;
        end else if (bus.i_cmd_valid && cmd_ready_r) begin
          mode_n   = bus.i_cmd_mode;
          ilen_n   = bus.i_cmd_ilen;
          olen_n   = olen_eff(bus.i_cmd_mode, bus.i_cmd_olen);
          bcnt_n   = {BW_IBLEN{1'b0}};
          lane_n   = {LANE_W{1'b0}};
          pack_n   = {BW_DATA{1'b0}};
          kword_n  = {BW_DATA{1'b0}};
          kvalid_n = 1'b0;
          ocnt_n   = {OW_W{1'b0}};
          ofull_n  = 1'b0;
          state_n  = ST_SEND;
        end else begin
          state_n = ST_IDLE;
        end
      end
      ST_SEND: begin
        if (kvalid_r) begin
          if (bus.i_kc_ibytes_ready) begin
            kvalid_n = 1'b0;
            state_n  = (bcnt_r == ilen_r) ? ST_COLLECT : ST_SEND;
          end else begin
            kvalid_n = 1'b1;
          end
        end else if (bus.i_msg_valid && msg_ready_r) begin
          bcnt_n = bcnt_inc_s;
          if ((lane_r == LANE_W'(NB - 1)) || (bcnt_inc_s == ilen_r)) begin
            kword_n  = pack_s;
            kvalid_n = 1'b1;
            pack_n   = {BW_DATA{1'b0}};
            lane_n   = {LANE_W{1'b0}};
          end else begin
            pack_n = pack_s;
            lane_n = lane_r + LANE_W'(1'b1);
          end
        end else begin
          kvalid_n = 1'b0;
        end
      end
      ST_COLLECT: begin
        if (bus.i_kc_obytes_valid && !ofull_r) begin
          dvalid_n = 1'b1;
          if (ocnt_r == olast_s) begin
            ofull_n  = 1'b1;
            dlast_n  = 1'b1;
            nbytes_n = fin_nbytes_s;
            dout_n   = bus.i_kc_obytes & fin_mask_s;
          end else begin
            ocnt_n   = ocnt_r + OW_W'(1'b1);
            nbytes_n = 4'd8;
            dout_n   = bus.i_kc_obytes;
          end
        end else begin
          dvalid_n = 1'b0;
        end
        // A word arriving together with done still counts toward completeness.
        if (bus.i_kc_obytes_done) begin
          state_n = ST_DONE;
          done_n  = 1'b1;
          err_n   = !ofull_n;
        end else begin
          state_n = ST_COLLECT;
        end
      end
      ST_DONE: begin
        state_n = ST_IDLE;
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
    cmd_ready_n = (state_n == ST_IDLE);
    busy_n      = (state_n != ST_IDLE);
    msg_ready_n = (state_n == ST_SEND) && !kvalid_n && (bcnt_n < ilen_n);
  end

  // State and output registers.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_r     <= ST_IDLE;
      mode_r      <= 2'd0;
      ilen_r      <= {BW_IBLEN{1'b0}};
      olen_r      <= {BW_OBLEN{1'b0}};
      bcnt_r      <= {BW_IBLEN{1'b0}};
      lane_r      <= {LANE_W{1'b0}};
      pack_r      <= {BW_DATA{1'b0}};
      kword_r     <= {BW_DATA{1'b0}};
      kvalid_r    <= 1'b0;
      ocnt_r      <= {OW_W{1'b0}};
      ofull_r     <= 1'b0;
      dout_r      <= {BW_DATA{1'b0}};
      dvalid_r    <= 1'b0;
      dlast_r     <= 1'b0;
      nbytes_r    <= 4'd0;
      done_r      <= 1'b0;
      err_r       <= 1'b0;
      busy_r      <= 1'b0;
      cmd_ready_r <= 1'b0;
      msg_ready_r <= 1'b0;
    end else begin
      state_r     <= state_n;
      mode_r      <= mode_n;
      ilen_r      <= ilen_n;
      olen_r      <= olen_n;
      bcnt_r      <= bcnt_n;
      lane_r      <= lane_n;
      pack_r      <= pack_n;
      kword_r     <= kword_n;
      kvalid_r    <= kvalid_n;
      ocnt_r      <= ocnt_n;
      ofull_r     <= ofull_n;
      dout_r      <= dout_n;
      dvalid_r    <= dvalid_n;
      dlast_r     <= dlast_n;
      nbytes_r    <= nbytes_n;
      done_r      <= done_n;
      err_r       <= err_n;
      busy_r      <= busy_n;
      cmd_ready_r <= cmd_ready_n;
      msg_ready_r <= msg_ready_n;
    end
  end

  assign bus.o_cmd_ready       = cmd_ready_r;
  assign bus.o_msg_ready       = msg_ready_r;
  assign bus.o_kc_mode         = mode_r;
  assign bus.o_kc_ibytes       = kword_r;
  assign bus.o_kc_ibytes_valid = kvalid_r;
  assign bus.o_kc_ibytes_len   = ilen_r;
  assign bus.o_kc_obytes_len   = olen_r;
  assign bus.o_dout            = dout_r;
  assign bus.o_dout_valid      = dvalid_r;
  assign bus.o_dout_nbytes     = nbytes_r;
  assign bus.o_dout_last       = dlast_r;
  assign bus.o_done            = done_r;
  assign bus.o_err             = err_r;
  assign bus.o_busy            = busy_r;
endmodule

// File: tb/tb_keccak_host.sv
// Randomized self-checking bench for keccak_host with a byte/word level
// reference model of packing and output trimming.
module tb_keccak_host;
  logic clk = 1'b0;
  logic rstn;
  int   n_checks = 0;
  int   n_errors = 0;
  logic [7:0] msg_bytes [0:63];

  keccak_host_if #(.BW_DATA(64), .BW_IBLEN(16), .BW_OBLEN(16)) bus ();

  keccak_host #(.BW_DATA(64), .BW_IBLEN(16), .BW_OBLEN(16)) dut (
    .i_clk  (clk),
    .i_rstn (rstn),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    bus.i_cmd_valid       = 1'b0;
    bus.i_cmd_mode        = 2'd0;
    bus.i_cmd_ilen        = 16'd0;
    bus.i_cmd_olen        = 16'd0;
    bus.i_msg_byte        = 8'd0;
    bus.i_msg_valid       = 1'b0;
    bus.i_kc_ibytes_ready = 1'b0;
    bus.i_kc_obytes       = 64'd0;
    bus.i_kc_obytes_valid = 1'b0;
    bus.i_kc_obytes_done  = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_kc_ibytes"}, bus.o_kc_ibytes, 64'd0);
    check({tag, "_dout"}, bus.o_dout, 64'd0);
    check({tag, "_misc"}, {bus.o_cmd_ready, bus.o_msg_ready, bus.o_kc_mode, bus.o_kc_ibytes_valid,
                           bus.o_kc_ibytes_len, bus.o_kc_obytes_len, bus.o_dout_valid,
                           bus.o_dout_nbytes, bus.o_dout_last, bus.o_done, bus.o_err, bus.o_busy}, 64'd0);
  endtask

  task automatic fill_random(input int n);
    for (int i = 0; i < n; i++) msg_bytes[i] = 8'($urandom);
  endtask

  task automatic cmd_err(input logic [1:0] mode, input int ilen, input int olen);
    @(negedge clk);
    bus.i_cmd_valid = 1'b1;
    bus.i_cmd_mode  = mode;
    bus.i_cmd_ilen  = 16'(ilen);
    bus.i_cmd_olen  = 16'(olen);
    @(negedge clk);
    bus.i_cmd_valid = 1'b0;
    check("err_pulse", bus.o_err, 1'b1);
    check("err_busy", bus.o_busy, 1'b0);
    check("err_cmd_ready", bus.o_cmd_ready, 1'b1);
    @(negedge clk);
    check("err_clear", bus.o_err, 1'b0);
    check("err_busy_after", bus.o_busy, 1'b0);
  endtask

  // One full transaction; abort_at >= 0 returns mid-SEND after that many bytes.
  task automatic run_txn(input logic [1:0] mode, input int ilen, input int olen,
                         input int nspg, input bit stall, input int abort_at);
    logic [63:0] exp_kc [$];
    logic [63:0] w_exp, ew;
    int olen_eff, nw, nwi, k, w, stall_left, stray, j, nb, budget;
    bit stalled, mr, kv, mv, rdy, exp_v, exp_last;
    logic [3:0] exp_nb;

    olen_eff = (mode == 2'd2) ? 32 : (mode == 2'd3) ? 64 : olen;
    nw  = (olen_eff + 7) / 8;
    nwi = (ilen + 7) / 8;
    for (int wi = 0; wi < nwi; wi++) begin
      w_exp = 64'd0;
      for (int b = 0; b < 8; b++)
        w_exp = {w_exp[55:0], ((wi * 8 + b) < ilen) ? msg_bytes[wi * 8 + b] : 8'h00};
      exp_kc.push_back(w_exp);
    end

    @(negedge clk);
    bus.i_cmd_valid = 1'b1;
    bus.i_cmd_mode  = mode;
    bus.i_cmd_ilen  = 16'(ilen);
    bus.i_cmd_olen  = 16'(olen);
    @(negedge clk);
    bus.i_cmd_valid = 1'b0;
    check("start_busy", bus.o_busy, 1'b1);
    check("start_err", bus.o_err, 1'b0);
    check("kc_mode", bus.o_kc_mode, mode);
    check("kc_ilen", bus.o_kc_ibytes_len, ilen);
    check("kc_olen", bus.o_kc_obytes_len, olen_eff);

    k = 0; w = 0; stall_left = 0; stalled = 1'b0; stray = 0;
    for (budget = 0; budget < 4000 && w < nwi; budget++) begin
      mr = bus.o_msg_ready;
      kv = bus.o_kc_ibytes_valid;
      if (bus.o_dout_valid) stray++;
      if (kv) begin
        check("kc_word", bus.o_kc_ibytes, exp_kc[w]);
        check("msg_ready_pending", mr, 1'b0);
        if (stall && !stalled) begin
          stall_left = 5;
          stalled = 1'b1;
        end
      end
      if (stall_left > 0) begin
        rdy = 1'b0;
        stall_left--;
      end else begin
        rdy = ($urandom_range(0, 3) != 0);
      end
      if (kv && rdy) w++;
      mv = (k < ilen) && ($urandom_range(0, 4) != 0);
      bus.i_kc_ibytes_ready = rdy;
      bus.i_msg_valid = mv;
      bus.i_msg_byte  = (k < ilen) ? msg_bytes[k] : 8'h00;
      if (mv && mr) k++;
      bus.i_kc_obytes_valid = 1'($urandom);
      bus.i_kc_obytes       = {$urandom, $urandom};
      @(negedge clk);
      if (abort_at >= 0 && k >= abort_at) begin
        idle_inputs();
        return;
      end
    end
    idle_inputs();
    check("send_complete", w, nwi);
    check("bytes_sent", k, ilen);
    check("ignored_obytes", stray, 0);
    check("collect_busy", bus.o_busy, 1'b1);

    j = 0; exp_v = 1'b0; ew = 64'd0; exp_nb = 4'd0; exp_last = 1'b0;
    for (budget = 0; budget < 4000 && j < nspg; budget++) begin
      check("dout_valid", bus.o_dout_valid, exp_v);
      if (exp_v) begin
        check("dout_word", bus.o_dout, ew);
        check("dout_nbytes", bus.o_dout_nbytes, exp_nb);
        check("dout_last", bus.o_dout_last, exp_last);
      end
      if ($urandom_range(0, 3) != 0) begin
        bus.i_kc_obytes_valid = 1'b1;
        bus.i_kc_obytes = {$urandom, $urandom};
        ew = bus.i_kc_obytes;
        exp_v = (j < nw);
        exp_last = (j == nw - 1);
        nb = exp_last ? ((olen_eff % 8 == 0) ? 8 : olen_eff % 8) : 8;
        exp_nb = 4'(nb);
        for (int b = nb; b < 8; b++) ew[63 - 8 * b -: 8] = 8'h00;
        j++;
      end else begin
        bus.i_kc_obytes_valid = 1'b0;
        exp_v = 1'b0;
      end
      @(negedge clk);
    end
    check("dout_valid", bus.o_dout_valid, exp_v);
    if (exp_v) begin
      check("dout_word", bus.o_dout, ew);
      check("dout_nbytes", bus.o_dout_nbytes, exp_nb);
      check("dout_last", bus.o_dout_last, exp_last);
    end
    bus.i_kc_obytes_valid = 1'b0;
    bus.i_kc_obytes_done  = 1'b1;
    @(negedge clk);
    bus.i_kc_obytes_done = 1'b0;
    check("done_pulse", bus.o_done, 1'b1);
    check("done_err", bus.o_err, (nspg < nw) ? 1'b1 : 1'b0);
    check("done_no_dout", bus.o_dout_valid, 1'b0);
    check("done_no_last", bus.o_dout_last, 1'b0);
    @(negedge clk);
    check("after_done", bus.o_done, 1'b0);
    check("after_err", bus.o_err, 1'b0);
    check("after_busy", bus.o_busy, 1'b0);
    check("after_cmd_ready", bus.o_cmd_ready, 1'b1);
  endtask

  initial begin
    int mode, ilen, olen, oe, nw, nspg;
    rstn = 1'b0;
    idle_inputs();
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rstn = 1'b1;
    @(negedge clk);
    check("idle_cmd_ready", bus.o_cmd_ready, 1'b1);
    check("idle_busy", bus.o_busy, 1'b0);

    msg_bytes[0] = 8'h61; msg_bytes[1] = 8'h62; msg_bytes[2] = 8'h63;
    run_txn(2'd2, 3, 0, 4, 1'b0, -1);
    fill_random(16);
    run_txn(2'd0, 16, 34, 6, 1'b0, -1);
    fill_random(24);
    run_txn(2'd1, 24, 20, 3, 1'b1, -1);
    cmd_err(2'd0, 0, 10);
    cmd_err(2'd1, 8, 0);
    fill_random(10);
    run_txn(2'd3, 10, 0, 2, 1'b0, -1);

    fill_random(20);
    run_txn(2'd1, 20, 40, 5, 1'b0, 5);
    rstn = 1'b0;
    #1;
    check_all_zero("midreset");
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    check("midreset_cmd_ready", bus.o_cmd_ready, 1'b1);
    fill_random(20);
    run_txn(2'd1, 20, 40, 5, 1'b0, -1);

    repeat (12) begin
      mode = $urandom_range(0, 3);
      ilen = $urandom_range(1, 40);
      olen = $urandom_range(1, 80);
      oe   = (mode == 2) ? 32 : (mode == 3) ? 64 : olen;
      nw   = (oe + 7) / 8;
      nspg = ($urandom_range(0, 4) == 0) ? $urandom_range(1, nw) : nw + $urandom_range(0, 2);
      fill_random(ilen);
      run_txn(2'(mode), ilen, olen, nspg, 1'($urandom), -1);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1);
  end
endmodule
